adc_capture_mc: RTL and testbench

ADC_CAPTURE_MC -- requirements
Module: adc_capture_mc

---
 rtl/adc_capture_pkg.sv | 17 +
 rtl/adc_capture_mc_dpram_sc.sv | 29 ++
 rtl/adc_capture_mc.sv | 172 +++++++++++++++++
 tb/tb_adc_capture_mc.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared state type, field widths and helpers for the ADC capture block.
package adc_capture_pkg;
   localparam int DECIM_W = 8;
   localparam int DELAY_W = 16;
   localparam int DROP_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELAY,
      ST_CAPT,
      ST_HOLD
   } cap_state_t;

   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
   endfunction
endpackage

// File: rtl/adc_capture_mc_dpram_sc.sv
// Single-clock simple dual-port RAM with a registered read port; contents are
// deliberately not reset so the array maps onto block RAM.
module dpram_sc #(
   parameter int W  = 128,
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [0:(1<<AW)-1];
   logic [W-1:0] rdata_reg;

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (re)
         rdata_reg <= mem[raddr];
   end

   assign rdata = rdata_reg;
endmodule

// File: rtl/adc_capture_mc.sv
// Multi-channel ADC snapshot capture: trigger, delay, decimation and a
// ping-pong banked store read back through a two-stage pipeline.
module adc_capture_mc
   import adc_capture_pkg::*;
#(
   parameter int NCH = 2,
   parameter int SPC = 4,
   parameter int DW  = 16,
   parameter int AW  = 10
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      adc_val,
   input  logic [NCH*SPC*DW-1:0]     adc_dat,
   input  logic                      en,
   input  logic                      trig,
   input  logic [AW:0]               cfg_len,
   input  logic [DELAY_W-1:0]        cfg_delay,
   input  logic [DECIM_W-1:0]        cfg_decim,
   input  logic                      rd_en,
   input  logic [AW+$clog2(NCH)-1:0] rd_addr,
   output logic [SPC*DW-1:0]         rd_data,
   output logic                      rd_valid,
   output logic                      rd_ready,
   input  logic                      rd_release,
   output logic                      busy,
   output logic [DROP_W-1:0]         drop_cnt
);
   localparam int GW = NCH*SPC*DW;
   localparam int SW = SPC*DW;
   localparam int CW = $clog2(NCH);
   localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

   cap_state_t         state_reg;
   logic               wbank_reg;
   logic               rd_ready_reg;
   logic [DROP_W-1:0]  drop_cnt_reg;
   logic [DELAY_W-1:0] dly_cnt_reg;
   logic [DECIM_W-1:0] decim_reg;
   logic [DECIM_W-1:0] phase_reg;
   logic [AW-1:0]      last_reg;
   logic [AW-1:0]      wptr_reg;

   logic          trig_ok;
   logic [AW:0]   len_clamp;
   logic [AW:0]   len_m1;
   logic          wr_en;
   logic          wr_last;
   logic          flip;

   assign trig_ok = trig & en;

   // Zero-length requests still capture one group; oversize ones fill the bank.
   always_comb begin
      len_clamp = cfg_len;
      if (cfg_len == '0)
         len_clamp = (AW+1)'(1);
      else if (cfg_len > MAX_LEN)
         len_clamp = MAX_LEN;
   end

   assign len_m1  = len_clamp - (AW+1)'(1);
   assign wr_en   = (state_reg == ST_CAPT) && adc_val && (phase_reg == '0);
   assign wr_last = wr_en && (wptr_reg == last_reg);
   assign flip    = (wr_last && (!rd_ready_reg || rd_release)) ||
                    ((state_reg == ST_HOLD) && rd_release);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg    <= ST_IDLE;
         wbank_reg    <= 1'b0;
         rd_ready_reg <= 1'b0;
         drop_cnt_reg <= '0;
         dly_cnt_reg  <= '0;
         decim_reg    <= '0;
         phase_reg    <= '0;
         last_reg     <= '0;
         wptr_reg     <= '0;
      end else begin
         if (trig_ok && (state_reg != ST_IDLE))
            drop_cnt_reg <= sat_inc(drop_cnt_reg);

         if (flip) begin
            wbank_reg    <= ~wbank_reg;
            rd_ready_reg <= 1'b1;
         end else if (rd_release) begin
            rd_ready_reg <= 1'b0;
         end

         case (state_reg)
            ST_IDLE: begin
               if (trig_ok) begin
                  dly_cnt_reg <= cfg_delay;
                  decim_reg   <= cfg_decim;
                  last_reg    <= len_m1[AW-1:0];
                  phase_reg   <= '0;
                  wptr_reg    <= '0;
                  state_reg   <= (cfg_delay == '0) ? ST_CAPT : ST_DELAY;
               end
            end
            ST_DELAY: begin
               if (adc_val) begin
                  dly_cnt_reg <= dly_cnt_reg - DELAY_W'(1);
                  if (dly_cnt_reg == DELAY_W'(1))
                     state_reg <= ST_CAPT;
               end
            end
            ST_CAPT: begin
               if (adc_val) begin
                  phase_reg <= (phase_reg == decim_reg) ? '0 : phase_reg + DECIM_W'(1);
                  if (wr_last)
                     state_reg <= flip ? ST_IDLE : ST_HOLD;
                  else if (wr_en)
                     wptr_reg <= wptr_reg + AW'(1);
               end
            end
            ST_HOLD: begin
               if (rd_release)
                  state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   logic [GW-1:0] ram_q;
   logic [SW-1:0] chan_q [NCH];

   dpram_sc #(
      .W  (GW),
      .AW (AW+1)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr ({wbank_reg, wptr_reg}),
      .wdata (adc_dat),
      .re    (rd_en),
      .raddr ({~wbank_reg, rd_addr[AW-1:0]}),
      .rdata (ram_q)
   );

   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign chan_q[gi] = ram_q[gi*SW +: SW];
   end

   logic          rd_v1_reg;
   logic [CW-1:0] rd_ch_reg;
   logic          rd_valid_reg;
   logic [SW-1:0] rd_data_reg;

   // Channel select travels alongside the RAM access so the mux stage lines up.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_v1_reg    <= 1'b0;
         rd_ch_reg    <= '0;
         rd_valid_reg <= 1'b0;
         rd_data_reg  <= '0;
      end else begin
         rd_v1_reg    <= rd_en;
         rd_ch_reg    <= rd_addr[AW+CW-1:AW];
         rd_valid_reg <= rd_v1_reg;
         if (rd_v1_reg)
            rd_data_reg <= chan_q[rd_ch_reg];
      end
   end

   assign rd_data  = rd_data_reg;
   assign rd_valid = rd_valid_reg;
   assign rd_ready = rd_ready_reg;
   assign busy     = (state_reg != ST_IDLE);
   assign drop_cnt = drop_cnt_reg;
endmodule

// File: tb/tb_adc_capture_mc.sv
// Randomised and directed bench for adc_capture_mc against a capture-level
// reference model (beat indices, queues and bank images).
module tb_adc_capture_mc;
   localparam int NCH = 2;
   localparam int SPC = 4;
   localparam int DW  = 16;
   localparam int AW  = 8;
   localparam int GW  = NCH*SPC*DW;
   localparam int SW  = SPC*DW;

   logic          clk = 1'b0;
   logic          rstn, adc_val, en, trig, rd_en, rd_release;
   logic [GW-1:0] adc_dat;
   logic [AW:0]   cfg_len;
   logic [15:0]   cfg_delay;
   logic [7:0]    cfg_decim;
   logic [AW:0]   rd_addr;
   logic [SW-1:0] rd_data;
   logic          rd_valid, rd_ready, busy;
   logic [15:0]   drop_cnt;

   int n_chk  = 0;
   int n_pass = 0;
   int val_mode = 0;
   int beat_ctr = 0;

   always #5 clk = ~clk;

   adc_capture_mc #(.NCH(NCH), .SPC(SPC), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rstn(rstn), .adc_val(adc_val), .adc_dat(adc_dat),
      .en(en), .trig(trig), .cfg_len(cfg_len), .cfg_delay(cfg_delay),
      .cfg_decim(cfg_decim), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_release(rd_release), .busy(busy), .drop_cnt(drop_cnt)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Word (c,s) of beat v carries v*8 + c*4 + s.
   function automatic logic [GW-1:0] mk_dat(input int v);
      logic [GW-1:0] d;
      d = '0;
      for (int c = 0; c < NCH; c++)
         for (int s = 0; s < SPC; s++)
            d[(c*SPC+s)*DW +: DW] = 16'(v*8 + c*4 + s);
      return d;
   endfunction

   // ---------------- reference model ----------------
   bit            m_busy, m_ready, m_pending;
   int            m_beat, m_len, m_delay, m_decim, m_drop, m_rlen;
   logic [GW-1:0] m_stored [$];
   logic [GW-1:0] m_rbank [256];
   bit            pa_v, pa_chk, pb_v, pb_chk;
   logic [SW-1:0] pa_d, pb_d;

   // Advance the model by one clock edge using the inputs about to be sampled.
   task automatic m_step();
      int grp, ch;
      logic [GW-1:0] g;
      bit busy_pre, flip;
      grp = int'(rd_addr[AW-1:0]);
      ch  = int'(rd_addr[AW]);
      g   = m_rbank[grp];
      pb_v = pa_v; pb_chk = pa_chk; pb_d = pa_d;
      pa_v   = rd_en;
      pa_chk = rd_en && m_ready && (grp < m_rlen);
      pa_d   = g[ch*SW +: SW];
      if (!rstn) begin
         m_busy = 0; m_ready = 0; m_pending = 0; m_drop = 0; m_rlen = 0;
         m_stored.delete();
         pa_v = 0; pa_chk = 0; pb_v = 0; pb_chk = 0;
         return;
      end
      busy_pre = m_busy;
      flip = 0;
      if (busy_pre && !m_pending && adc_val) begin
         if (m_beat >= m_delay && ((m_beat - m_delay) % (m_decim + 1)) == 0) begin
            m_stored.push_back(adc_dat);
            if (m_stored.size() == m_len) begin
               if (!m_ready || rd_release) flip = 1;
               else m_pending = 1;
            end
         end
         m_beat++;
      end else if (m_pending && rd_release) begin
         flip = 1;
      end
      if (flip) begin
         for (int i = 0; i < m_len; i++) m_rbank[i] = m_stored[i];
         m_rlen = m_len; m_ready = 1; m_busy = 0; m_pending = 0;
      end else if (rd_release) begin
         m_ready = 0;
      end
      if (trig && en) begin
         if (busy_pre) begin
            if (m_drop < 65535) m_drop++;
         end else begin
            m_busy = 1; m_pending = 0; m_beat = 0;
            m_stored.delete();
            m_len = int'(cfg_len);
            if (m_len == 0) m_len = 1;
            if (m_len > 256) m_len = 256;
            m_delay = int'(cfg_delay);
            m_decim = int'(cfg_decim);
         end
      end
   endtask

   initial begin
      bit m_on;
      m_on = 0;
      forever begin
         @(negedge clk);
         if (m_on) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("rd_ready", 64'(rd_ready), 64'(m_ready));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            chk("rd_valid", 64'(rd_valid), 64'(pb_v));
            if (pb_chk) chk("rd_data", 64'(rd_data), 64'(pb_d));
         end
         m_step();
         if (!rstn) m_on = 1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      trig = 0; rd_release = 0; rd_en = 0;
      case (val_mode)
         0:       adc_val = 1'b1;
         1:       adc_val = ~adc_val;
         default: adc_val = 1'($urandom_range(0, 1));
      endcase
      adc_dat = mk_dat(beat_ctr);
      if (adc_val) beat_ctr++;
   endtask

   task automatic wait_idle(input int maxc);
      int n;
      n = 0;
      while (busy && n < maxc) begin tick(); n++; end
      chk("wait_idle_timeout", 64'(busy), 64'd0);
   endtask

   task automatic read_one(input int ch, input int grp, output logic [SW-1:0] d);
      rd_en = 1;
      rd_addr = {1'(ch), 8'(grp)};
      tick();
      tick();
      chk("rd_valid_lat2", 64'(rd_valid), 64'd1);
      d = rd_data;
   endtask

   task automatic start(input int len, input int dly, input int dec, input int base);
      cfg_len = 9'(len); cfg_delay = 16'(dly); cfg_decim = 8'(dec);
      en = 1; trig = 1;
      beat_ctr = base;
   endtask

   initial begin
      logic [SW-1:0] d;
      rstn = 0; adc_val = 0; adc_dat = '0; en = 0; trig = 0; rd_en = 0;
      rd_release = 0; cfg_len = '0; cfg_delay = '0; cfg_decim = '0; rd_addr = '0;
      repeat (3) tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rd_ready", 64'(rd_ready), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_rd_data", 64'(rd_data), 64'd0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      rstn = 1;
      tick();

      // Ramp capture of 16 groups, no delay or decimation.
      val_mode = 0;
      start(16, 0, 0, 0);
      repeat (16) tick();
      chk("s1_ready_before", 64'(rd_ready), 64'd0);
      tick();
      chk("s1_ready_after16", 64'(rd_ready), 64'd1);
      for (int g = 0; g < 16; g++) begin
         rd_en = 1; rd_addr = {1'b1, 8'(g)};
         tick();
      end
      tick(); tick();
      read_one(1, 15, d);
      chk("s1_ch1_g15", 64'(d), 64'h007F_007E_007D_007C);
      rd_release = 1;
      tick();
      tick();
      chk("s1_release_clears", 64'(rd_ready), 64'd0);

      // Delay 5, decimate by 3, beats every other cycle.
      val_mode = 1;
      start(4, 5, 2, 0);
      tick();
      wait_idle(100);
      chk("s2_ready", 64'(rd_ready), 64'd1);
      read_one(0, 0, d);
      chk("s2_ch0_g0_beat5", 64'(d), 64'h002B_002A_0029_0028);
      read_one(1, 2, d);
      chk("s2_ch1_g2_beat11", 64'(d), 64'h005F_005E_005D_005C);
      read_one(1, 3, d);
      chk("s2_ch1_g3_beat14", 64'(d), 64'h0077_0076_0075_0074);

      // Second capture completes while the first bank is still held.
      val_mode = 0;
      start(8, 0, 0, 1000);
      repeat (12) tick();
      chk("s3_hold_busy", 64'(busy), 64'd1);
      chk("s3_hold_ready", 64'(rd_ready), 64'd1);
      read_one(0, 0, d);
      chk("s3_old_bank", 64'(d), 64'h002B_002A_0029_0028);
      rd_release = 1;
      tick();
      chk("s3_flip_ready", 64'(rd_ready), 64'd1);
      chk("s3_flip_idle", 64'(busy), 64'd0);
      read_one(0, 0, d);
      chk("s3_new_bank", 64'(d), 64'h1F43_1F42_1F41_1F40);

      // Triggers during DELAY, CAPT and HOLD are dropped; en=0 is ignored.
      start(4, 6, 1, 2000);
      for (int i = 1; i <= 18; i++) begin
         tick();
         en = 1;
         if (i == 1 || i == 8 || i == 16) trig = 1;
         if (i == 17) begin trig = 1; en = 0; end
      end
      chk("s4_hold", 64'(busy), 64'd1);
      rd_release = 1;
      tick();
      tick();
      chk("s4_drop_cnt", 64'(drop_cnt), 64'd3);
      read_one(0, 1, d);
      chk("s4_ch0_g1_beat8", 64'(d), 64'h3EC3_3EC2_3EC1_3EC0);

      // Reset in the middle of a capture.
      start(32, 0, 0, 2500);
      repeat (5) tick();
      rstn = 0;
      tick();
      chk("s5_busy", 64'(busy), 64'd0);
      chk("s5_ready", 64'(rd_ready), 64'd0);
      chk("s5_wbank", 64'(dut.wbank_reg), 64'd0);
      chk("s5_drop", 64'(drop_cnt), 64'd0);
      rstn = 1;

      // Length 0 captures one group, length 300 captures the full bank.
      start(0, 0, 0, 3000);
      tick();
      wait_idle(20);
      chk("s6_len0_ready", 64'(rd_ready), 64'd1);
      read_one(1, 0, d);
      chk("s6_len0_g0", 64'(d), 64'h5DC7_5DC6_5DC5_5DC4);
      rd_release = 1;
      tick();
      start(300, 0, 0, 4000);
      tick();
      repeat (255) tick();
      chk("s6_len300_busy_255", 64'(busy), 64'd1);
      tick();
      chk("s6_len300_done", 64'(busy), 64'd0);
      read_one(0, 255, d);
      chk("s6_len300_g255", 64'(d), 64'h84FB_84FA_84F9_84F8);

      // Random traffic against the model.
      val_mode = 2;
      for (int i = 0; i < 4000; i++) begin
         tick();
         en = ($urandom_range(0, 7) != 0);
         trig = ($urandom_range(0, 29) == 0);
         cfg_len = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 20));
         cfg_delay = 16'($urandom_range(0, 8));
         cfg_decim = 8'($urandom_range(0, 3));
         rd_en = 1'($urandom_range(0, 1));
         rd_addr = 9'($urandom_range(0, 511));
         rd_release = ($urandom_range(0, 19) == 0);
         rstn = ($urandom_range(0, 1499) != 0);
      end
      rstn = 1;
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
